dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the MIPS core data port (cpu) and the Mandelbrot pixel engine (pix).
- Sits between `top`'s core/pixel-engine instances and the dmem block RAM.
- Issues at most one memory command per cycle, using round-robin arbitration plus an urgent override for pix.
- Returns read data after a fixed memory latency, with a per-requester valid.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arbiter_rd_tag_pipe.sv | 39 +++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default bus widths
//   owner_e  : which requester a read belongs to (OWN_CPU = 0, OWN_PIX = 1)
//   rd_tag_t : one entry of the read-return tag pipeline
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 12;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PIX = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters (cpu, pix), the arbiter and
// the data memory.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            read valids, rdata and the memory command)
//   master : requester/memory view (the opposite directions)
interface dmem_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  // cpu data port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  // pixel engine port
  logic              pix_req;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_wdata;
  logic              pix_urgent;
  logic              pix_gnt;
  logic              pix_rvalid;

  // shared read data
  logic [DATA_W-1:0] rdata;

  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  pix_req, pix_we, pix_addr, pix_wdata, pix_urgent,
    output pix_gnt, pix_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output pix_req, pix_we, pix_addr, pix_wdata, pix_urgent,
    input  pix_gnt, pix_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of {valid, owner} tags that tracks
// reads in flight through the memory, so the returning word can be steered
// to the requester that issued it.
//   clk     : clock
//   rst     : asynchronous active-low clear (drops every in-flight tag)
//   tag_in  : tag for the command issued this cycle (valid = 0 when no read)
//   tag_out : tag whose data is on mem_rdata this cycle
module rd_tag_pipe
  import mips_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_reg [RD_LAT];

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg[gi] <= '0;
          else      stage_reg[gi] <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg[gi] <= '0;
          else      stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MIPS core
// data port (cpu) and the Mandelbrot pixel engine (pix). At most one command
// per cycle; round-robin between the two with an urgent override for pix.
// Read data comes back RD_LAT cycles after the grant with a per-requester
// valid; rdata is mem_rdata passed through.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : dmem_arbiter_if.slave (requests, grants, read valids, rdata and
//         the memory command/response)
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  owner_e            last_reg;
  owner_e            last_next;
  logic              cpu_win;
  logic              pix_win;
  logic              cpu_gnt;
  logic              pix_gnt;
  logic              mem_we_sel;
  logic [ADDR_W-1:0] mem_addr_sel;
  logic [DATA_W-1:0] mem_wdata_sel;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  // Arbitration and round-robin pointer update.
  always_comb begin
    cpu_win   = 1'b0;
    pix_win   = 1'b0;
    last_next = last_reg;

    if (bus.cpu_req && bus.pix_req) begin
      // Tie: urgent pix always wins, otherwise the one not served last.
      if (bus.pix_urgent || (last_reg == OWN_CPU)) pix_win = 1'b1;
      else                                         cpu_win = 1'b1;
    end else begin
      cpu_win = bus.cpu_req;
      pix_win = bus.pix_req;
    end

    // Grants are combinational, so gate them with the (active-low) reset to
    // keep the memory quiet while reset is held.
    cpu_gnt = cpu_win & rst;
    pix_gnt = pix_win & rst;

    if (cpu_gnt)      last_next = OWN_CPU;
    else if (pix_gnt) last_next = OWN_PIX;
  end

  // Reset to pix so that cpu wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_reg <= OWN_PIX;
    else      last_reg <= last_next;
  end

  // Memory command mux. With no grant, address/data follow the cpu inputs
  // and the write enable stays low.
  always_comb begin
    mem_we_sel    = 1'b0;
    mem_addr_sel  = bus.cpu_addr;
    mem_wdata_sel = bus.cpu_wdata;
    if (pix_gnt) begin
      mem_we_sel    = bus.pix_we;
      mem_addr_sel  = bus.pix_addr;
      mem_wdata_sel = bus.pix_wdata;
    end else if (cpu_gnt) begin
      mem_we_sel    = bus.cpu_we;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.pix_gnt   = pix_gnt;
  assign bus.mem_en    = cpu_gnt | pix_gnt;
  assign bus.mem_we    = mem_we_sel;
  assign bus.mem_addr  = mem_addr_sel;
  assign bus.mem_wdata = mem_wdata_sel;

  // Only granted reads occupy a valid slot; writes and idle cycles push a
  // bubble so the tail stays aligned with mem_rdata.
  always_comb begin
    tag_in.valid = (cpu_gnt | pix_gnt) & ~mem_we_sel;
    tag_in.owner = pix_gnt ? OWN_PIX : OWN_CPU;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.cpu_rvalid = tag_out.valid & (tag_out.owner == OWN_CPU);
  assign bus.pix_rvalid = tag_out.valid & (tag_out.owner == OWN_PIX);
  assign bus.rdata      = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Three instances (RD_LAT = 1, 3, 2)
// receive identical stimulus, each with its own memory model. The driver
// sets inputs #1 after the rising edge and records the expected grant/memory
// command plus, for reads, the expected {owner, data, grant cycle} in a
// queue. A single checker on the falling edge compares grants/memory command
// and consumes the queue whenever an instance shows a read valid, checking
// owner, data and exact latency.
module tb_dmem_arbiter;

  localparam int LATS [3] = '{1, 3, 2};

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic        cpu_req, cpu_we, pix_req, pix_we, pix_urgent;
  logic [11:0] cpu_addr, pix_addr;
  logic [31:0] cpu_wdata, pix_wdata;
  logic        mem_clr;

  // expectations written by the driver only
  logic        chk_en;
  logic        exp_cg, exp_pg, exp_en, exp_we;
  logic [11:0] exp_addr;
  logic [31:0] exp_wd;
  logic        done;
  exp_t        exp_q[$];

  // observed outputs from each instance
  logic        cpu_gnt_w    [3];
  logic        pix_gnt_w    [3];
  logic        mem_en_w     [3];
  logic        mem_we_w     [3];
  logic [11:0] mem_addr_w   [3];
  logic [31:0] mem_wdata_w  [3];
  logic        cpu_rvalid_w [3];
  logic        pix_rvalid_w [3];
  logic [31:0] rdata_w      [3];

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LAT = LATS[gi];

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.cpu_req    = cpu_req;
    assign bus.cpu_we     = cpu_we;
    assign bus.cpu_addr   = cpu_addr;
    assign bus.cpu_wdata  = cpu_wdata;
    assign bus.pix_req    = pix_req;
    assign bus.pix_we     = pix_we;
    assign bus.pix_addr   = pix_addr;
    assign bus.pix_wdata  = pix_wdata;
    assign bus.pix_urgent = pix_urgent;

    assign cpu_gnt_w[gi]    = bus.cpu_gnt;
    assign pix_gnt_w[gi]    = bus.pix_gnt;
    assign mem_en_w[gi]     = bus.mem_en;
    assign mem_we_w[gi]     = bus.mem_we;
    assign mem_addr_w[gi]   = bus.mem_addr;
    assign mem_wdata_w[gi]  = bus.mem_wdata;
    assign cpu_rvalid_w[gi] = bus.cpu_rvalid;
    assign pix_rvalid_w[gi] = bus.pix_rvalid;
    assign rdata_w[gi]      = bus.rdata;

    // memory model: unwritten words read as init_word(addr)
    logic [31:0]   mem [4096];
    logic [4095:0] written;
    logic [31:0]   dly [LAT];

    always @(posedge clk) begin
      if (mem_clr) written <= '0;
      else if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_en && !bus.mem_we)
        dly[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
      else
        dly[0] <= 32'h0;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end

    assign bus.mem_rdata = dly[LAT-1];
  end

  // ---------------------------------------------------------------- driver
  task automatic step(input bit cr, input bit cwe, input logic [11:0] ca,
                      input logic [31:0] cwd, input bit pr, input bit pwe,
                      input logic [11:0] pa, input logic [31:0] pwd,
                      input bit urg, input bit ecg, input bit epg,
                      input logic [31:0] edata, input bit keep);
    @(posedge clk);
    #1;
    cpu_req = cr;  cpu_we = cwe;  cpu_addr = ca;  cpu_wdata = cwd;
    pix_req = pr;  pix_we = pwe;  pix_addr = pa;  pix_wdata = pwd;
    pix_urgent = urg;
    exp_cg   = ecg;
    exp_pg   = epg;
    exp_en   = ecg | epg;
    exp_we   = epg ? pwe : (ecg ? cwe : 1'b0);
    exp_addr = epg ? pa : ca;
    exp_wd   = epg ? pwd : cwd;
    chk_en   = 1'b1;
    if (keep && ((ecg && !cwe) || (epg && !pwe)))
      exp_q.push_back('{owner: epg, data: edata, gcyc: cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    pix_req = 0; pix_we = 0; pix_addr = '0; pix_wdata = '0; pix_urgent = 0;
  endtask

  // Assert reset, hold both requests during it (no grants allowed), release.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    chk_en = 1'b0;
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_clr = 1'b0;
    clear_inputs();
    chk_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mem_clr = 1'b1;
    chk_en = 1'b0;
    done = 1'b0;
    exp_cg = 0; exp_pg = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0;
    clear_inputs();
    do_reset();

    // lone cpu read after reset
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h000, 32'h0, 0, 1, 0, 32'hDEADBEEF, 1);
    idle(4);

    // first tie after reset: cpu, pix, cpu, pix
    do_reset();
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 1, 0, 32'hC0DE0001, 1);
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 0, 1, 32'hC0DE0002, 1);
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 1, 0, 32'hC0DE0001, 1);
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 0, 1, 32'hC0DE0002, 1);

    // urgent pix wins four times, then cpu gets the next tie
    repeat (4)
      step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 1, 0, 1, 32'hC0DE0002, 1);
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 1, 0, 32'hC0DE0001, 1);
    idle(4);

    // pix write, then cpu reads it back
    step(0, 0, 12'h000, 32'h0, 1, 1, 12'h3FF, 32'h00FF00FF, 0, 0, 1, 32'h0, 1);
    step(1, 0, 12'h3FF, 32'h0, 0, 0, 12'h000, 32'h0, 0, 1, 0, 32'h00FF00FF, 1);
    idle(4);

    // back-to-back cpu reads stream in order
    step(1, 0, 12'h004, 32'h0, 0, 0, 12'h000, 32'h0, 0, 1, 0, 32'hC0DE0004, 1);
    step(1, 0, 12'h005, 32'h0, 0, 0, 12'h000, 32'h0, 0, 1, 0, 32'hC0DE0005, 1);
    step(1, 0, 12'h006, 32'h0, 0, 0, 12'h000, 32'h0, 0, 1, 0, 32'hC0DE0006, 1);
    idle(5);

    // pix read, reset the next cycle: its data must never be flagged
    step(0, 0, 12'h000, 32'h0, 1, 0, 12'h002, 32'h0, 0, 0, 1, 32'h0, 0);
    do_reset();
    step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0, 1, 0, 32'hC0DE0001, 1);
    idle(5);

    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- checker
  int n_cmp = 0;
  int n_bad = 0;
  int rd_idx [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (cpu_gnt_w[0] !== exp_cg || pix_gnt_w[0] !== exp_pg) begin
        n_bad++;
        $display("FAIL gnt cyc=%0d got cpu=%b pix=%b required cpu=%b pix=%b",
                 cyc, cpu_gnt_w[0], pix_gnt_w[0], exp_cg, exp_pg);
      end
      n_cmp++;
      if (mem_en_w[0] !== exp_en || mem_we_w[0] !== exp_we ||
          mem_addr_w[0] !== exp_addr || mem_wdata_w[0] !== exp_wd) begin
        n_bad++;
        $display("FAIL mem_cmd cyc=%0d got en=%b we=%b addr=%h wd=%h required en=%b we=%b addr=%h wd=%h",
                 cyc, mem_en_w[0], mem_we_w[0], mem_addr_w[0], mem_wdata_w[0],
                 exp_en, exp_we, exp_addr, exp_wd);
      end
    end

    for (int k = 0; k < 3; k++) begin
      if (cpu_rvalid_w[k] === 1'b1 || pix_rvalid_w[k] === 1'b1) begin
        n_cmp++;
        if (rd_idx[k] >= exp_q.size()) begin
          n_bad++;
          $display("FAIL rvalid_unexpected lat=%0d cyc=%0d got cpu_rv=%b pix_rv=%b required none",
                   LATS[k], cyc, cpu_rvalid_w[k], pix_rvalid_w[k]);
        end else begin
          exp_t e;
          e = exp_q[rd_idx[k]];
          rd_idx[k] = rd_idx[k] + 1;
          if ({cpu_rvalid_w[k], pix_rvalid_w[k]} !== {~e.owner, e.owner} ||
              rdata_w[k] !== e.data || cyc != e.gcyc + LATS[k]) begin
            n_bad++;
            $display("FAIL rdata lat=%0d got cyc=%0d cpu_rv=%b pix_rv=%b data=%h required cyc=%0d cpu_rv=%b pix_rv=%b data=%h",
                     LATS[k], cyc, cpu_rvalid_w[k], pix_rvalid_w[k], rdata_w[k],
                     e.gcyc + LATS[k], ~e.owner, e.owner, e.data);
          end
        end
      end else if (rd_idx[k] < exp_q.size() &&
                   exp_q[rd_idx[k]].gcyc + LATS[k] < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_missing lat=%0d cyc=%0d got none required data=%h at cyc=%0d",
                 LATS[k], cyc, exp_q[rd_idx[k]].data, exp_q[rd_idx[k]].gcyc + LATS[k]);
        rd_idx[k] = rd_idx[k] + 1;
      end
    end

    if (done) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (rd_idx[k] != exp_q.size()) begin
          n_bad++;
          $display("FAIL drain lat=%0d got %0d reads returned required %0d",
                   LATS[k], rd_idx[k], exp_q.size());
        end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule
